reset_sequencer: RTL
====================

Name: reset_sequencer

Overview:
- Parametrised periodic/triggered reset generator for the converter test tops.
- Drives N_CH staggered active-high reset lines into the ADC/DAC driver instances, with a status LED and a counter of reset events.
- Generalises the fixed divide-by-100, once-per-minute, single-reset scheme:
  - per-channel staggered release
  - programmable period, pulse width and prescale
  - run-time enable
  - manual trigger

Parameters:
- N_CH, 2, number of reset outputs (1..8).
- PRESCALE, 100, clk_in cycles per tick (>=1).
- PULSE, 500000, ticks all outputs stay asserted (>=1).
- STAGGER, 1000, ticks between successive channel releases (>=0).
- PERIOD, 60000000, ticks per auto cycle; must exceed PULSE+(N_CH-1)*STAGGER.
- CNT_W, 30, width of the tick counter; must hold PERIOD-1.

Ports:
- clk_in  input  1  system clock (100 MHz, from BUFG).
- rst_n_in  input  1  asynchronous, active-low reset. Deassertion is already synchronous to clk_in upstream.
- en_in  input  1  auto-repeat enable; level, synchronous.
- trig_in  input  1  manual trigger; asynchronous, synchronised internally.
- rst_out  output  N_CH  active-high resets; bit k releases k-th.
- busy_out  output  1  high from cycle start until the last channel is released.
- led_out  output  1  high when all rst_out are low.
- cycle_cnt_out  output  16  number of reset cycles started since rst_n_in; saturating.

Behaviour:
- rst_n_in low (async) sets:
  - rst_out all ones, busy_out=1, led_out=0, cycle_cnt_out=0
  - prescaler pre=0, tick counter p=0, trigger synchroniser cleared
  - state ASSERT
- Prescaler: pre counts 0..PRESCALE-1 each clk_in edge. tick=1 on the edge where pre==PRESCALE-1, and pre wraps to 0 on that edge.
- p increments on each tick. All outputs are registered and update on the same edge as p.
- Per-channel release:
  - rst_out[k]=1 while p < PULSE+k*STAGGER; 0 otherwise.
  - Channels with equal thresholds (STAGGER=0) release on the same edge.
- busy_out=1 while p < PULSE+(N_CH-1)*STAGGER.
- led_out = ~|rst_out, registered in lockstep with rst_out (no extra delay).
- States, derived from p:
  - ASSERT: p<PULSE.
  - RELEASE: PULSE<=p<last threshold.
  - RUN: after the last channel is released.
  - HOLD: p==PERIOD-1 with en_in=0.
- Wrap, on a tick with p==PERIOD-1:
  - If en_in=1: p<=0, all rst_out<=1, busy_out<=1, cycle_cnt_out+=1 (saturates at 0xFFFF).
  - If en_in=0: p holds at PERIOD-1 (HOLD), outputs unchanged.
  - Raising en_in while in HOLD restarts on the next tick.
- Auto period = PERIOD*PRESCALE clk_in cycles.
- Manual trigger:
  - trig_in passes through a 2-FF synchroniser plus edge detect.
  - A synchronised rising edge while busy_out=0 sets, on the next edge: p<=0, pre<=0, all rst_out<=1, busy_out<=1, cycle_cnt_out+=1.
  - Triggers while busy_out=1 are ignored (not queued).
  - If a trigger and a wrap tick coincide, perform one restart only and increment cycle_cnt_out once.
- The initial power-on cycle after rst_n_in is not counted.
- rst_n_in asserted mid-cycle: immediate return to reset values; the sequence restarts from p=0 on release.
- en_in does not affect an in-progress ASSERT/RELEASE.

Test Plan:
- N_CH=3, PRESCALE=4, PULSE=3, STAGGER=2, PERIOD=20, en_in=1, release rst_n_in (edge 1 = first edge after release):
  - rst_out[0] falls at edge 12, rst_out[1] at edge 20, rst_out[2] at edge 28.
  - busy_out falls at edge 28, led_out rises at edge 28.
- Same config, continue:
  - At edge 80 all rst_out=1 and cycle_cnt_out=1.
  - At edge 160 cycle_cnt_out=2; release pattern repeats at +80.
- en_in=0 before edge 76: p holds at 19, no restart, cycle_cnt_out stays 0. Raise en_in: restart on the next tick edge.
- Pulse trig_in for 2 cycles at edge 40 (RUN): restart about 3 edges later, pre=0, cycle_cnt_out=1, rst_out[0] falls 12 edges after restart.
- trig_in pulsed at edge 15 (busy): ignored; rst_out timing identical to the first scenario.
- rst_n_in low for 1 cycle at edge 22: rst_out=3'b111 immediately (async), cycle_cnt_out=0; sequence restarts with the first scenario's timing.
- Saturation: force cycle_cnt_out to 0xFFFF, then trigger a wrap: it stays 0xFFFF.

Source files
------------

// File: rtl/reset_sequencer_if.sv
// Control and status bundle of the reset sequencer.
// The master drives enable/trigger and the slave returns reset lines and status.
interface reset_sequencer_if #(
  parameter int N_CH = 2
);
  logic            en_in;
  logic            trig_in;
  logic [N_CH-1:0] rst_out;
  logic            busy_out;
  logic            led_out;
  logic [15:0]     cycle_cnt_out;

  modport master (
    output en_in,
    output trig_in,
    input  rst_out,
    input  busy_out,
    input  led_out,
    input  cycle_cnt_out
  );

  modport slave (
    input  en_in,
    input  trig_in,
    output rst_out,
    output busy_out,
    output led_out,
    output cycle_cnt_out
  );
endinterface

// File: rtl/reset_sequencer.sv
// Periodic/triggered reset generator with staggered per-channel release.
// Counts prescaled ticks and releases each channel at its own threshold.
module reset_sequencer #(
  parameter int N_CH     = 2,
  parameter int PRESCALE = 100,
  parameter int PULSE    = 500000,
  parameter int STAGGER  = 1000,
  parameter int PERIOD   = 60000000,
  parameter int CNT_W    = 30
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  reset_sequencer_if.slave   bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int LAST = PULSE + (N_CH - 1) * STAGGER;

  localparam logic [PW-1:0]    PRE_END = PW'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] P_END   = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] P_PULSE = CNT_W'(PULSE);
  localparam logic [CNT_W-1:0] P_LAST  = CNT_W'(LAST);

  typedef enum logic [1:0] {
    ASSERT,
    RELEASE,
    RUN,
    HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [CNT_W-1:0] p_q, p_d;
  logic [N_CH-1:0]  rst_q, rst_d;
  logic             led_q, led_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [2:0]       sync_q;

  logic tick;
  logic busy;
  logic rise;
  logic restart;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ASSERT;
      pre_q   <= '0;
      p_q     <= '0;
      rst_q   <= '1;
      led_q   <= 1'b0;
      cnt_q   <= '0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      p_q     <= p_d;
      rst_q   <= rst_d;
      led_q   <= led_d;
      cnt_q   <= cnt_d;
      sync_q  <= {sync_q[1:0], bus.trig_in};
    end
  end

  // sync_q[2] is the previous synchronised sample, used for edge detect
  always_comb begin
    pre_d   = pre_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    rst_d   = rst_q;
    led_d   = led_q;
    state_d = state_q;

    tick    = (pre_q == PRE_END);
    busy    = (state_q == ASSERT) || (state_q == RELEASE);
    rise    = sync_q[1] & ~sync_q[2];
    restart = (rise & ~busy)
            | (tick & (p_q == P_END) & bus.en_in);

    pre_d = tick ? '0 : pre_q + PW'(1);

    if (restart) begin
      pre_d = '0;
      p_d   = '0;
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end else if (tick && (p_q != P_END)) begin
      p_d = p_q + CNT_W'(1);
    end

    for (int k = 0; k < N_CH; k++) begin
      rst_d[k] = (p_d < CNT_W'(PULSE + k * STAGGER));
    end
    led_d = ~|rst_d;

    if (p_d < P_PULSE) begin
      state_d = ASSERT;
    end else if (p_d < P_LAST) begin
      state_d = RELEASE;
    end else if ((p_d == P_END) && !bus.en_in) begin
      state_d = HOLD;
    end else begin
      state_d = RUN;
    end
  end

  assign bus.rst_out       = rst_q;
  assign bus.busy_out      = busy;
  assign bus.led_out       = led_q;
  assign bus.cycle_cnt_out = cnt_q;

endmodule
